// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared bundle/state types and helpers for the fetch front end
package fetch_unit_pkg;
  localparam int BUNDLE_BYTES = 8;
  typedef struct packed {
    logic        v2;
    logic [31:0] w0;
    logic [31:0] w1;
  } fetch_bundle_t;
  typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN, F_DONE} fetch_state_t;
  function automatic logic [31:0] bundle_align(input logic [31:0] a);
    return a & ~32'(BUNDLE_BYTES - 1);
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem read port plus the decode valid/ready bundle handshake
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        dec_ready;
  logic        en_flag_di;
  logic [31:0] instr_1;
  logic [31:0] instr_2;
  modport master (output imem_addr, en_flag_di, instr_1, instr_2, input imem_rdata, dec_ready);
  modport slave (input imem_addr, en_flag_di, instr_1, instr_2, output imem_rdata, dec_ready);
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_unit_queue: sync FIFO of fetch bundles; extra pointer bit separates full from empty
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  fetch_bundle_t din,
  output fetch_bundle_t head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_bundle_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(pop);
    end
  // At full with a same-cycle pop the write lands in the slot being vacated
  always_ff @(posedge clk)
    if (push && !clear) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: 2-wide in-order fetch; pc, run/drain FSM, instruction counter, bundle queue to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int IMEM_BYTES = 128,
  parameter int QDEPTH     = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [31:0]      flush_pc,
  fetch_unit_if.master     bus,
  output logic             fetch_done,
  output logic [CNT_W-1:0] total_instr_count
);
  fetch_state_t  state;
  fetch_bundle_t head, din;
  logic [31:0]   pc, w0, w1;
  logic          q_full, q_empty, pop, room, push, stop;
  logic [1:0]    inc;
  logic [CNT_W:0] sum;
  assign w0 = bus.imem_rdata[63:32];
  assign w1 = bus.imem_rdata[31:0];
  assign pop = !q_empty && bus.dec_ready && !flush;
  assign room = state == F_RUN && !flush && (!q_full || pop);
  assign push = room && w0 != '0;
  // End of program or end of imem: pc stays on the last bundle read
  assign stop = w0 == '0 || w1 == '0 || pc + 32'd8 >= 32'(IMEM_BYTES);
  assign inc = push ? (w1 == '0 ? 2'd1 : 2'd2) : 2'd0;
  assign sum = {1'b0, total_instr_count} + (CNT_W+1)'(inc);
  assign din = '{v2: w1 != '0, w0: w0, w1: w1};
  fetch_unit_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (q_full),
    .empty (q_empty)
  );
  assign bus.imem_addr = pc;
  assign bus.en_flag_di = !q_empty;
  assign bus.instr_1 = head.w0;
  assign bus.instr_2 = head.v2 ? head.w1 : '0;
  assign fetch_done = state == F_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= F_IDLE;
      pc    <= '0;
    end else if (flush) begin
      state <= F_RUN;
      pc    <= bundle_align(flush_pc);
    end else
      case (state)
        F_IDLE:  state <= start ? F_RUN : F_IDLE;
        F_RUN:
          if (room) begin
            state <= stop ? F_DRAIN : F_RUN;
            pc    <= stop ? pc : pc + 32'd8;
          end
        F_DRAIN: state <= q_empty ? F_DONE : F_DRAIN;
        default: state <= state;
      endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) total_instr_count <= '0;
    else total_instr_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests against a queue-level model of the fetch front end
module tb_fetch_unit;
  localparam int QD = 4;
  localparam int MB = 128;
  logic clk = 1'b0;
  logic rst_n, start, flush;
  logic [31:0] flush_pc;
  logic fetch_done;
  logic [31:0] total_instr_count;
  fetch_unit_if bus();
  fetch_unit #(.IMEM_BYTES(MB), .QDEPTH(QD), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .bus               (bus),
    .fetch_done        (fetch_done),
    .total_instr_count (total_instr_count)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [0:MB-1];
  logic [63:0] rd;
  always_comb begin
    rd = '0;
    for (int k = 0; k < 8; k++) rd[63-8*k -: 8] = mem[{bus.imem_addr[6:3], 3'(k)}];
  end
  assign bus.imem_rdata = rd;
  int total = 0;
  int bad = 0;
  logic [63:0] mq [$];
  logic [63:0] dlv [$];
  logic [31:0] mpc = 0;
  int mst = 0;
  int mcnt = 0;
  bit m_pop, m_fits, m_empty;
  logic [31:0] ma, mb;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] wd(int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction
  task automatic setw(int i, logic [31:0] v);
    {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]} = v;
  endtask
  task automatic clr();
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(int lim);
    int n = 0;
    while (!fetch_done && n < lim) begin
      tick();
      n++;
    end
    chk("done_wait", 64'(fetch_done), 64'd1);
  endtask
  // Model: mst 0 idle, 1 fetching, 2 draining, 3 done; mq holds {w0,w1} bundles
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (rst_n !== 1'b1) begin
      mq.delete();
      mpc = 0;
      mst = 0;
      mcnt = 0;
    end else if (flush) begin
      mq.delete();
      mpc = flush_pc & 32'hFFFF_FFF8;
      mst = 1;
    end else begin
      m_empty = mq.size() == 0;
      m_pop = !m_empty && bus.dec_ready;
      m_fits = mq.size() < QD || m_pop;
      ma = wd(int'(mpc));
      mb = wd(int'(mpc) + 4);
      if (m_pop) void'(mq.pop_front());
      if (mst == 0 && start) mst = 1;
      else if (mst == 1 && m_fits) begin
        if (ma == 0) mst = 2;
        else begin
          mq.push_back({ma, mb});
          mcnt += (mb == 0) ? 1 : 2;
          if (mb == 0 || mpc + 8 >= MB) mst = 2;
          else mpc += 8;
        end
      end else if (mst == 2 && m_empty) mst = 3;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("en_flag_di", 64'(bus.en_flag_di), 64'(mq.size() != 0));
      chk("bundle", {bus.instr_1, bus.instr_2}, mq.size() != 0 ? mq[0] : 64'd0);
      chk("imem_addr", 64'(bus.imem_addr), 64'(mpc));
      chk("fetch_done", 64'(fetch_done), 64'(mst == 3));
      chk("count", 64'(total_instr_count), 64'(mcnt));
      if (bus.en_flag_di && bus.dec_ready && !flush) dlv.push_back({bus.instr_1, bus.instr_2});
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] pat;
    logic [63:0] h;
    int s;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    bus.dec_ready = 1'b0;
    clr();
    tick();
    // async reset mid-RUN with 3 bundles queued
    reset_dut();
    for (int i = 0; i < 16; i++) setw(i, 32'h100 + 32'(i));
    pulse_start();
    repeat (3) tick();
    chk("t1_queued", 64'(bus.en_flag_di), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_en", 64'(bus.en_flag_di), 64'd0);
    chk("t1_instr", {bus.instr_1, bus.instr_2}, 64'd0);
    chk("t1_addr", 64'(bus.imem_addr), 64'd0);
    chk("t1_cnt", 64'(total_instr_count), 64'd0);
    chk("t1_done", 64'(fetch_done), 64'd0);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("t1_idle_en", 64'(bus.en_flag_di), 64'd0);
    chk("t1_idle_addr", 64'(bus.imem_addr), 64'd0);
    // words 1..6 then zeros
    reset_dut();
    clr();
    for (int i = 0; i < 6; i++) setw(i, 32'(i + 1));
    bus.dec_ready = 1'b1;
    pulse_start();
    dlv.delete();
    wait_done(20);
    chk("t2_n", 64'(dlv.size()), 64'd3);
    chk("t2_b0", dlv[0], 64'h00000001_00000002);
    chk("t2_b1", dlv[1], 64'h00000003_00000004);
    chk("t2_b2", dlv[2], 64'h00000005_00000006);
    chk("t2_cnt", 64'(total_instr_count), 64'd6);
    // A,B,C,0
    reset_dut();
    clr();
    setw(0, 32'hAAAA0001);
    setw(1, 32'hBBBB0002);
    setw(2, 32'hCCCC0003);
    pulse_start();
    dlv.delete();
    @(negedge clk);
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pat = {pat[1:0], bus.en_flag_di};
    end
    chk("t3_pattern", 64'(pat), 64'b110);
    wait_done(20);
    chk("t3_b0", dlv[0], 64'hAAAA0001_BBBB0002);
    chk("t3_b1", dlv[1], 64'hCCCC0003_00000000);
    chk("t3_cnt", 64'(total_instr_count), 64'd3);
    // backpressure fills queue, then streaming at full
    reset_dut();
    clr();
    for (int i = 0; i < 16; i++) setw(i, 32'h100 + 32'(i));
    bus.dec_ready = 1'b0;
    pulse_start();
    repeat (5) tick();
    h = {bus.instr_1, bus.instr_2};
    repeat (5) tick();
    chk("t4_stable", {bus.instr_1, bus.instr_2}, h);
    chk("t4_head", {bus.instr_1, bus.instr_2}, 64'h00000100_00000101);
    chk("t4_pc", 64'(bus.imem_addr), 64'd32);
    bus.dec_ready = 1'b1;
    dlv.delete();
    s = 0;
    repeat (8) begin
      @(negedge clk);
      s += int'(bus.en_flag_di);
    end
    chk("t5_stream", 64'(s), 64'd8);
    wait_done(40);
    chk("t4_n", 64'(dlv.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("t4_order", dlv[i], {32'(256 + 2*i), 32'(257 + 2*i)});
    chk("t4_cnt", 64'(total_instr_count), 64'd16);
    // flush with 2 queued
    reset_dut();
    bus.dec_ready = 1'b0;
    pulse_start();
    repeat (2) tick();
    chk("t6_pre_cnt", 64'(total_instr_count), 64'd4);
    flush = 1'b1;
    flush_pc = 32'h13;
    tick();
    flush = 1'b0;
    chk("t6_en", 64'(bus.en_flag_di), 64'd0);
    chk("t6_addr", 64'(bus.imem_addr), 64'h10);
    chk("t6_cnt", 64'(total_instr_count), 64'd4);
    chk("t6_done", 64'(fetch_done), 64'd0);
    tick();
    chk("t6_refetch", {bus.instr_1, bus.instr_2}, 64'h00000104_00000105);
    bus.dec_ready = 1'b1;
    wait_done(40);
    chk("t6_cnt_end", 64'(total_instr_count), 64'd16);
    // full imem: stop at the last bundle without wrapping
    reset_dut();
    for (int i = 0; i < 32; i++) setw(i, 32'h200 + 32'(i));
    pulse_start();
    dlv.delete();
    wait_done(60);
    chk("t7_n", 64'(dlv.size()), 64'd16);
    chk("t7_last", dlv[15], 64'h0000021E_0000021F);
    chk("t7_pc", 64'(bus.imem_addr), 64'd120);
    chk("t7_cnt", 64'(total_instr_count), 64'd32);
    // flush out of DONE restarts fetch
    flush = 1'b1;
    flush_pc = 32'h70;
    tick();
    flush = 1'b0;
    chk("t8_done", 64'(fetch_done), 64'd0);
    chk("t8_addr", 64'(bus.imem_addr), 64'h70);
    wait_done(20);
    chk("t8_cnt", 64'(total_instr_count), 64'd36);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
